// File: rtl/spi_host_core.sv
// SPI mode-0 initiator core (CPOL=0, CPHA=0, MSB first).
// Bytes arrive on a valid/ready stream; each received MISO byte is returned as a
// one-cycle strobe. spi_clk is generated from clk by a programmable half-period divider.
module spi_host_core #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 spi_clk,
    output logic                 spi_cs_n,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [7:0]           usr_mosi_data,
    input  logic                 usr_mosi_last,
    input  logic                 usr_mosi_valid,
    output logic                 usr_mosi_ready,
    input  logic                 usr_cs_release,
    output logic [7:0]           usr_miso_data,
    output logic                 usr_miso_stb,
    output logic                 busy
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StWait,
        StHold,
        StGap
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [3:0]           edge_q, edge_d;
    logic [7:0]           tx_q, tx_d;
    logic [7:0]           rx_q, rx_d;
    logic                 last_q, last_d;
    logic                 spi_clk_q, spi_clk_d;
    logic                 cs_n_q, cs_n_d;
    logic                 mosi_q, mosi_d;
    logic                 ready_q, ready_d;
    logic [7:0]           miso_data_q, miso_data_d;
    logic                 stb_q, stb_d;

    logic accept;
    logic tick;

    assign accept = usr_mosi_valid & ready_q;
    assign tick   = (cnt_q == div_q);

    // Main sequencer: state transitions, shift registers and spi_clk toggling.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        edge_d      = edge_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        last_d      = last_q;
        spi_clk_d   = spi_clk_q;
        miso_data_d = miso_data_q;
        stb_d       = 1'b0;

        unique case (state_q)
            StIdle, StWait: begin
                spi_clk_d = 1'b0;
                if (accept) begin
                    // An accept always wins over a simultaneous release request.
                    state_d = StSetup;
                    tx_d    = usr_mosi_data;
                    last_d  = usr_mosi_last;
                    div_d   = cfg_div;
                end else if ((state_q == StWait) && usr_cs_release) begin
                    state_d = StHold;
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d   = StShift;
                    spi_clk_d = 1'b1;
                    edge_d    = 4'd0;
                end
            end
            StShift: begin
                if (tick) begin
                    spi_clk_d = ~spi_clk_q;
                    edge_d    = edge_q + 4'd1;
                    // Even edge count means this tick is a falling spi_clk edge.
                    if (!edge_q[0]) begin
                        rx_d = {rx_q[6:0], spi_miso};
                        if (edge_q == 4'd14) begin
                            // 8th falling edge: byte done, MOSI keeps bit 0.
                            miso_data_d = {rx_q[6:0], spi_miso};
                            stb_d       = 1'b1;
                            state_d     = last_q ? StHold : StWait;
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Half-period counter: restarts on every state entry and after each tick.
    always_comb begin
        cnt_d = '0;
        if ((state_q == StSetup) || (state_q == StShift) ||
            (state_q == StHold) || (state_q == StGap)) begin
            if ((state_d == state_q) && !tick) begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
            end
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Registered pin and handshake values derived from the next state.
    always_comb begin
        cs_n_d  = (state_d == StIdle) || (state_d == StGap);
        mosi_d  = cs_n_d ? 1'b0 : tx_d[7];
        ready_d = (state_d == StIdle) || (state_d == StWait);
    end

    // State and output registers; reset forces the idle bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            div_q       <= '0;
            edge_q      <= 4'd0;
            tx_q        <= 8'h00;
            rx_q        <= 8'h00;
            last_q      <= 1'b0;
            spi_clk_q   <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            miso_data_q <= 8'h00;
            stb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            edge_q      <= edge_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            last_q      <= last_d;
            spi_clk_q   <= spi_clk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            miso_data_q <= miso_data_d;
            stb_q       <= stb_d;
        end
    end

    assign spi_clk        = spi_clk_q;
    assign spi_cs_n       = cs_n_q;
    assign spi_mosi       = mosi_q;
    assign usr_mosi_ready = ready_q;
    assign usr_miso_data  = miso_data_q;
    assign usr_miso_stb   = stb_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_spi_host_core.sv
// Directed bench for spi_host_core: cycle-exact checks against hand-computed timing.
module tb_spi_host_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] cfg_div = 8'd0;
    logic [7:0] usr_mosi_data = 8'h00;
    logic       usr_mosi_last = 1'b0;
    logic       usr_mosi_valid = 1'b0;
    logic       usr_mosi_ready;
    logic       usr_cs_release = 1'b0;
    logic [7:0] usr_miso_data;
    logic       usr_miso_stb;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int rise_cnt = 0;
    int stb_cnt  = 0;
    logic [7:0] mosi_cap = 8'h00;

    // Slave model: presents slave_byte MSB first, advancing on each falling spi_clk.
    logic       loop_en = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    logic [2:0] sl_idx = 3'd0;

    assign spi_miso = loop_en ? spi_mosi : slave_byte[3'd7 - sl_idx];

    spi_host_core #(.DIV_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_clk        (spi_clk),
        .spi_cs_n       (spi_cs_n),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .cfg_div        (cfg_div),
        .usr_mosi_data  (usr_mosi_data),
        .usr_mosi_last  (usr_mosi_last),
        .usr_mosi_valid (usr_mosi_valid),
        .usr_mosi_ready (usr_mosi_ready),
        .usr_cs_release (usr_cs_release),
        .usr_miso_data  (usr_miso_data),
        .usr_miso_stb   (usr_miso_stb),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (usr_miso_stb === 1'b1) stb_cnt <= stb_cnt + 1;
    always @(posedge spi_clk) begin
        rise_cnt <= rise_cnt + 1;
        mosi_cap <= {mosi_cap[6:0], spi_mosi};
    end
    always @(negedge spi_clk or posedge rst) begin
        if (rst) sl_idx <= 3'd0;
        else     sl_idx <= sl_idx + 3'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Offers a byte and returns the accept edge number; called and returns at a negedge.
    task automatic send(input logic [7:0] d, input logic l, input logic rel, output int e);
        int n;
        n = 0;
        usr_mosi_data  = d;
        usr_mosi_last  = l;
        usr_mosi_valid = 1'b1;
        usr_cs_release = rel;
        while ((usr_mosi_ready !== 1'b1) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 200), 32'd1);
        e = cyc + 1;
        @(negedge clk);
        usr_mosi_valid = 1'b0;
        usr_cs_release = 1'b0;
    endtask

    initial begin
        int e, e2, r, bad, rise_base, stb_base;

        // Reset state
        @(negedge clk);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_clk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_ready", usr_mosi_ready, 0);
        chk("rst_data", usr_miso_data, 8'h00);
        chk("rst_stb", usr_miso_stb, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", usr_mosi_ready, 1);

        // D=0, 0xA5 with last, loopback
        loop_en = 1'b1;
        cfg_div = 8'd0;
        rise_base = rise_cnt;
        send(8'hA5, 1'b1, 1'b0, e);
        chk("t1_cs_low", spi_cs_n, 0);
        chk("t1_mosi_b7", spi_mosi, 1);
        chk("t1_clk_low", spi_clk, 0);
        chk("t1_ready_low", usr_mosi_ready, 0);
        chk("t1_busy", busy, 1);
        wait_until(e + 1);  chk("t1_rise1", spi_clk, 1);
        wait_until(e + 2);  chk("t1_fall1", spi_clk, 0);
        chk("t1_mosi_b6", spi_mosi, 0);
        wait_until(e + 15); chk("t1_stb_early", usr_miso_stb, 0);
        wait_until(e + 16); chk("t1_stb", usr_miso_stb, 1);
        chk("t1_data", usr_miso_data, 8'hA5);
        chk("t1_cs_hold", spi_cs_n, 0);
        chk("t1_rises", 32'(rise_cnt - rise_base), 8);
        chk("t1_mosi_bits", mosi_cap, 8'hA5);
        wait_until(e + 17); chk("t1_cs_high", spi_cs_n, 1);
        chk("t1_stb_once", usr_miso_stb, 0);
        chk("t1_ready_gap", usr_mosi_ready, 0);
        wait_until(e + 18); chk("t1_ready", usr_mosi_ready, 1);
        chk("t1_idle", busy, 0);

        // D=3, 0x3C then 0xC3 last; slave returns 0x5A, 0x96
        loop_en = 1'b0;
        slave_byte = 8'h5A;
        cfg_div = 8'd3;
        send(8'h3C, 1'b0, 1'b0, e);
        wait_until(e + 3);  chk("t2_setup_low", spi_clk, 0);
        wait_until(e + 4);  chk("t2_rise1", spi_clk, 1);
        wait_until(e + 7);  chk("t2_high4", spi_clk, 1);
        wait_until(e + 8);  chk("t2_fall1", spi_clk, 0);
        wait_until(e + 11); chk("t2_low4", spi_clk, 0);
        wait_until(e + 12); chk("t2_rise2", spi_clk, 1);
        wait_until(e + 64); chk("t2_stb1", usr_miso_stb, 1);
        chk("t2_data1", usr_miso_data, 8'h5A);
        chk("t2_ready_wait", usr_mosi_ready, 1);
        chk("t2_mosi1", mosi_cap, 8'h3C);
        wait_until(e + 65); chk("t2_cs_between", spi_cs_n, 0);
        slave_byte = 8'h96;
        send(8'hC3, 1'b1, 1'b0, e2);
        wait_until(e2 + 64); chk("t2_stb2", usr_miso_stb, 1);
        chk("t2_data2", usr_miso_data, 8'h96);
        chk("t2_mosi2", mosi_cap, 8'hC3);
        wait_until(e2 + 67); chk("t2_hold", spi_cs_n, 0);
        wait_until(e2 + 68); chk("t2_cs_high", spi_cs_n, 1);
        wait_until(e2 + 71); chk("t2_gap_ready", usr_mosi_ready, 0);
        wait_until(e2 + 72); chk("t2_ready", usr_mosi_ready, 1);

        // D=1, 0x11 not last, 20 idle cycles in WAIT, then release
        loop_en = 1'b1;
        cfg_div = 8'd1;
        send(8'h11, 1'b0, 1'b0, e);
        wait_until(e + 32); chk("t3_stb", usr_miso_stb, 1);
        chk("t3_data", usr_miso_data, 8'h11);
        rise_base = rise_cnt;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((spi_cs_n !== 1'b0) || (spi_clk !== 1'b0)) bad++;
        end
        chk("t3_wait_bus", bad, 0);
        usr_cs_release = 1'b1;
        r = cyc + 1;
        @(negedge clk);
        usr_cs_release = 1'b0;
        chk("t3_rel_ready", usr_mosi_ready, 0);
        wait_until(r + 1); chk("t3_cs_still_low", spi_cs_n, 0);
        wait_until(r + 2); chk("t3_cs_high", spi_cs_n, 1);
        wait_until(r + 3); chk("t3_gap_ready", usr_mosi_ready, 0);
        wait_until(r + 4); chk("t3_ready", usr_mosi_ready, 1);
        chk("t3_no_edges", 32'(rise_cnt - rise_base), 0);

        // D=0, valid and release together in WAIT
        cfg_div = 8'd0;
        send(8'h24, 1'b0, 1'b0, e);
        wait_until(e + 16); chk("t4_data0", usr_miso_data, 8'h24);
        send(8'h81, 1'b0, 1'b1, e2);
        chk("t4_cs_low", spi_cs_n, 0);
        chk("t4_busy", busy, 1);
        wait_until(e2 + 16); chk("t4_stb", usr_miso_stb, 1);
        chk("t4_data", usr_miso_data, 8'h81);
        chk("t4_mosi", mosi_cap, 8'h81);
        wait_until(e2 + 20); chk("t4_cs_kept", spi_cs_n, 0);
        chk("t4_ready", usr_mosi_ready, 1);

        // D=2, reset after the 3rd rising edge
        cfg_div = 8'd2;
        rise_base = rise_cnt;
        stb_base = stb_cnt;
        send(8'hFF, 1'b1, 1'b0, e);
        wait_until(e + 15); chk("t5_rise3", spi_clk, 1);
        chk("t5_rise_cnt", 32'(rise_cnt - rise_base), 3);
        rst = 1'b1;
        #1;
        chk("t5_cs_n", spi_cs_n, 1);
        chk("t5_clk", spi_clk, 0);
        chk("t5_mosi", spi_mosi, 0);
        chk("t5_ready", usr_mosi_ready, 0);
        chk("t5_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_no_stb", 32'(stb_cnt - stb_base), 0);
        @(negedge clk);
        chk("t5_ready_after", usr_mosi_ready, 1);
        chk("t5_data_clr", usr_miso_data, 8'h00);

        // cfg_div 1 -> 5 mid-byte
        cfg_div = 8'd1;
        send(8'h5A, 1'b1, 1'b0, e);
        cfg_div = 8'd5;
        wait_until(e + 1);  chk("t6_setup", spi_clk, 0);
        wait_until(e + 2);  chk("t6_rise1", spi_clk, 1);
        wait_until(e + 3);  chk("t6_high", spi_clk, 1);
        wait_until(e + 4);  chk("t6_fall1", spi_clk, 0);
        wait_until(e + 32); chk("t6_stb", usr_miso_stb, 1);
        chk("t6_data", usr_miso_data, 8'h5A);
        wait_until(e + 35); chk("t6_gap_ready", usr_mosi_ready, 0);
        wait_until(e + 36); chk("t6_ready", usr_mosi_ready, 1);
        send(8'h0F, 1'b1, 1'b0, e2);
        wait_until(e2 + 5);  chk("t6b_setup", spi_clk, 0);
        wait_until(e2 + 6);  chk("t6b_rise1", spi_clk, 1);
        wait_until(e2 + 11); chk("t6b_high", spi_clk, 1);
        wait_until(e2 + 12); chk("t6b_fall1", spi_clk, 0);
        wait_until(e2 + 96); chk("t6b_stb", usr_miso_stb, 1);
        chk("t6b_data", usr_miso_data, 8'h0F);
        chk("t6b_mosi", mosi_cap, 8'h0F);
        wait_until(e2 + 101); chk("t6b_hold", spi_cs_n, 0);
        wait_until(e2 + 102); chk("t6b_cs_high", spi_cs_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
